// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared serializer state encoding and parity-mode constants
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Mode 3 is reserved and behaves like PAR_NONE.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with show-ahead read port and occupancy count
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with per-frame latched configuration
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          tx_sig,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import uart_pkg::*;

    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    tx_state_e               state;
    logic [DIV_WIDTH-1:0]    div_q;
    logic [1:0]              par_q;
    logic                    stop2_q;
    logic                    par_bit_q;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [DIV_WIDTH-1:0]    clk_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    bit_done;

    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    fifo_pop;
    logic [DATA_WIDTH-1:0]   fifo_dout;

    assign ready_out = !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign busy      = (state != ST_IDLE);
    assign bit_done  = (clk_cnt == div_q - DIV_WIDTH'(1));

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (valid_in && ready_out),
        .push_data (data_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Line level decodes straight from state so an async reset idles the line at once.
    always_comb begin
        tx_sig = 1'b1;
        case (state)
            ST_START:  tx_sig = 1'b0;
            ST_DATA:   tx_sig = shreg[0];
            ST_PARITY: tx_sig = par_bit_q;
            default:   tx_sig = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            div_q     <= DIV_WIDTH'(2);
            par_q     <= PAR_NONE;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
            shreg     <= '0;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            if (state != ST_IDLE) begin
                clk_cnt <= bit_done ? '0 : clk_cnt + DIV_WIDTH'(1);
            end
            case (state)
                ST_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (!fifo_empty) begin
                        state     <= ST_START;
                        div_q     <= (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;
                        par_q     <= cfg_parity;
                        stop2_q   <= cfg_stop2;
                        shreg     <= fifo_dout;
                        par_bit_q <= (^fifo_dout) ^ (cfg_parity == PAR_ODD);
                    end
                end
                ST_START: begin
                    if (bit_done) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (bit_done) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= parity_enabled(par_q) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) state <= ST_STOP;
                end
                ST_STOP: begin
                    // bit_cnt marks the second stop period when two are configured.
                    if (bit_done) begin
                        if (stop2_q && (bit_cnt == '0)) begin
                            bit_cnt <= BIT_W'(1);
                        end else begin
                            bit_cnt <= '0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int DW = 8;
    localparam int FD = 4;
    localparam int VW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          ready_out;
    logic [VW-1:0] cfg_div;
    logic [1:0]    cfg_parity;
    logic          cfg_stop2;
    logic          tx_sig;
    logic          busy;
    logic [2:0]    fifo_level;

    int total = 0;
    int bad   = 0;

    logic [127:0] tx_vec;
    logic [127:0] busy_vec;

    logic       rx_en  = 1'b0;
    int         rx_div = 8;
    logic       rx_par = 1'b0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .DIV_WIDTH  (VW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .cfg_div    (cfg_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx_sig     (tx_sig),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        data_in  = w;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic capture(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            tx_vec[start+i]   = tx_sig;
            busy_vec[start+i] = busy;
            tick();
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy || fifo_level != 0) && n < bound) begin
            tick();
            n++;
        end
        total++;
        if (busy || fifo_level != 0) begin
            bad++;
            $display("FAIL wait_idle: busy=%0b level=%0d after %0d cycles, required idle", busy, fifo_level, n);
        end
    endtask

    // Mid-bit sampling receiver for order checks; framing length comes from rx_div/rx_par.
    initial begin : rx_proc
        logic [7:0] d;
        d = '0;
        forever begin
            tick();
            if (rx_en && !rst && tx_sig == 1'b0) begin
                repeat (rx_div / 2) tick();
                for (int b = 0; b < 8; b++) begin
                    repeat (rx_div) tick();
                    d[b] = tx_sig;
                end
                repeat (rx_div * (rx_par ? 2 : 1)) tick();
                rx_q.push_back(d);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (tx_sig !== 1'b1)      begin bad++; $display("FAIL reset_tx: got %0b want 1", tx_sig); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (ready_out !== 1'b1)   begin bad++; $display("FAIL reset_ready: got %0b want 1", ready_out); end
        total++; if (fifo_level !== 3'd0)  begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        rst = 1'b0;
        push(8'h3C);
        total++; if (fifo_level !== 3'd1)  begin bad++; $display("FAIL first_push: level got %0d want 1", fifo_level); end
        wait_idle(200);
    endtask

    task automatic test_basic();
        logic [9:0]   f;
        logic [127:0] etx, ebusy;
        f = 10'b1101001010;
        cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        etx = '0; ebusy = '0; tx_vec = '0; busy_vec = '0;
        for (int i = 0; i < 40; i++) begin etx[i] = f[i/4]; ebusy[i] = 1'b1; end
        etx[40] = 1'b1;
        push(8'hA5);
        tick();
        capture(0, 41);
        total++; if (tx_vec !== etx)    begin bad++; $display("FAIL basic_tx: got %h want %h", tx_vec, etx); end
        total++; if (busy_vec !== ebusy) begin bad++; $display("FAIL basic_busy: got %h want %h", busy_vec, ebusy); end
        wait_idle(100);
    endtask

    task automatic test_parity();
        logic [10:0]  fe, fo;
        logic [127:0] etx, ebusy;
        fe = 11'b11000001110;
        fo = 11'b10000001110;
        cfg_div = 16'd4; cfg_stop2 = 1'b0;
        for (int m = 1; m <= 2; m++) begin
            cfg_parity = 2'(m);
            etx = '0; ebusy = '0; tx_vec = '0; busy_vec = '0;
            for (int i = 0; i < 44; i++) begin
                etx[i]   = (m == 1) ? fe[i/4] : fo[i/4];
                ebusy[i] = 1'b1;
            end
            etx[44] = 1'b1;
            push(8'h07);
            tick();
            capture(0, 45);
            total++; if (tx_vec !== etx)    begin bad++; $display("FAIL parity%0d_tx: got %h want %h", m, tx_vec, etx); end
            total++; if (busy_vec !== ebusy) begin bad++; $display("FAIL parity%0d_busy: got %h want %h", m, busy_vec, ebusy); end
            wait_idle(100);
        end
        cfg_parity = 2'd0;
    endtask

    task automatic test_back_to_back();
        logic [10:0]  f0, f1;
        logic [127:0] etx, ebusy;
        f0 = 11'b11000000000;
        f1 = 11'b11111111110;
        cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b1;
        etx = '0; ebusy = '0; tx_vec = '0; busy_vec = '0;
        for (int i = 0; i < 44; i++)  begin etx[i] = f0[i/4];      ebusy[i] = 1'b1; end
        etx[44] = 1'b1;
        for (int i = 45; i < 89; i++) begin etx[i] = f1[(i-45)/4]; ebusy[i] = 1'b1; end
        etx[89] = 1'b1;
        push(8'h00);
        push(8'hFF);
        capture(0, 90);
        total++; if (tx_vec !== etx)    begin bad++; $display("FAIL b2b_tx: got %h want %h", tx_vec, etx); end
        total++; if (busy_vec !== ebusy) begin bad++; $display("FAIL b2b_busy: got %h want %h", busy_vec, ebusy); end
        cfg_stop2 = 1'b0;
        wait_idle(100);
    endtask

    task automatic test_fifo_full();
        logic [7:0] words [6];
        logic [5:0] acc;
        int         n;
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        cfg_div = 16'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        rx_div = 8; rx_par = 1'b0; rx_q.delete(); rx_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data_in  = words[k];
            valid_in = 1'b1;
            acc[k]   = ready_out;
            tick();
        end
        valid_in = 1'b0;
        total++; if (acc !== 6'b011111)    begin bad++; $display("FAIL fifo_accept: got %b want 011111", acc); end
        total++; if (fifo_level !== 3'd4)  begin bad++; $display("FAIL fifo_level_full: got %0d want 4", fifo_level); end
        total++; if (ready_out !== 1'b0)   begin bad++; $display("FAIL fifo_ready_full: got %0b want 0", ready_out); end
        n = 0;
        while (ready_out == 1'b0 && n < 200) begin tick(); n++; end
        total++; if (n != 77)              begin bad++; $display("FAIL fifo_ready_low_cycles: got %0d want 77", n); end
        n = 0;
        while (rx_q.size() < 5 && n < 1000) begin tick(); n++; end
        wait_idle(200);
        repeat (50) tick();
        total++; if (rx_q.size() != 5)     begin bad++; $display("FAIL fifo_frame_count: got %0d want 5", rx_q.size()); end
        for (int k = 0; k < rx_q.size() && k < 5; k++) begin
            total++;
            if (rx_q[k] !== words[k]) begin bad++; $display("FAIL fifo_order%0d: got %h want %h", k, rx_q[k], words[k]); end
        end
        rx_en = 1'b0;
    endtask

    task automatic test_divisor();
        logic [9:0]   fa, fb;
        logic [127:0] etx, ebusy;
        fa = 10'b1101001010;
        fb = 10'b1010110100;
        cfg_div = 16'd0; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        etx = '0; ebusy = '0; tx_vec = '0; busy_vec = '0;
        for (int i = 0; i < 20; i++) begin etx[i] = fa[i/2]; ebusy[i] = 1'b1; end
        etx[20] = 1'b1;
        push(8'hA5);
        tick();
        capture(0, 21);
        total++; if (tx_vec !== etx)    begin bad++; $display("FAIL div0_tx: got %h want %h", tx_vec, etx); end
        total++; if (busy_vec !== ebusy) begin bad++; $display("FAIL div0_busy: got %h want %h", busy_vec, ebusy); end
        wait_idle(100);

        cfg_div = 16'd4;
        etx = '0; ebusy = '0; tx_vec = '0; busy_vec = '0;
        for (int i = 0; i < 40; i++)   begin etx[i] = fa[i/4];      ebusy[i] = 1'b1; end
        etx[40] = 1'b1;
        for (int i = 41; i < 121; i++) begin etx[i] = fb[(i-41)/8]; ebusy[i] = 1'b1; end
        etx[121] = 1'b1;
        push(8'hA5);
        push(8'h5A);
        capture(0, 10);
        cfg_div = 16'd8;
        capture(10, 112);
        total++; if (tx_vec !== etx)    begin bad++; $display("FAIL divchg_tx: got %h want %h", tx_vec, etx); end
        total++; if (busy_vec !== ebusy) begin bad++; $display("FAIL divchg_busy: got %h want %h", busy_vec, ebusy); end
        wait_idle(100);
    endtask

    task automatic test_reset_mid_frame();
        int activity;
        cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        push(8'h00);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL rmid_queued: got %0d want 3", fifo_level); end
        repeat (6) tick();
        total++; if (tx_sig !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rmid_in_data: tx=%0b busy=%0b want tx=0 busy=1", tx_sig, busy); end
        #2 rst = 1'b1;
        #1;
        total++; if (tx_sig !== 1'b1)     begin bad++; $display("FAIL rmid_tx: got %0b want 1", tx_sig); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rmid_busy: got %0b want 0", busy); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rmid_level: got %0d want 0", fifo_level); end
        total++; if (ready_out !== 1'b1)  begin bad++; $display("FAIL rmid_ready: got %0b want 1", ready_out); end
        repeat (2) tick();
        rst = 1'b0;
        activity = 0;
        for (int i = 0; i < 300; i++) begin
            if (tx_sig !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) activity++;
            tick();
        end
        total++; if (activity != 0) begin bad++; $display("FAIL rmid_no_frames: got %0d active cycles want 0", activity); end
    endtask

    initial begin
        rst        = 1'b1;
        data_in    = '0;
        valid_in   = 1'b0;
        cfg_div    = 16'd4;
        cfg_parity = 2'd0;
        cfg_stop2  = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_fifo_full();
        test_divisor();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
